// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: baud tick sizing, receive FSM
// states and the oversampling points used by the majority vote.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE    = 16;
    localparam int BITS_PER_BYTE = 8;

    localparam logic [3:0] SAMPLE_FIRST = 4'd7;
    localparam logic [3:0] SAMPLE_LAST  = 4'd9;
    localparam logic [3:0] SAMPLE_END   = 4'd15;

    // Integer truncation is intended: the residual rate error is absorbed by
    // the mid-bit majority vote.
    function automatic int calc_clks_per_tick(input int clk_frequency, input int baud);
        return clk_frequency / (baud * OVERSAMPLE);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on pop_data_o without
// a read request. DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra wrap bit separates full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately left without reset; only the
    // pointers define occupancy, and the empty gate below hides stale data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote, feeding
// a show-ahead byte FIFO with a valid/ready consumer port.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD          = 115_200,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int                CLKS_PER_TICK = calc_clks_per_tick(CLK_FREQUENCY, BAUD);
    localparam int                TICK_W        = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST     = TICK_W'(CLKS_PER_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_ONE      = TICK_W'(1);
    localparam logic [2:0]        BIT_LAST      = 3'(BITS_PER_BYTE - 1);

    // Synchronizer and start-edge qualification
    logic       rxd_meta_q;
    logic       rxs_q;
    logic       rxs_prev_q;
    logic [1:0] sync_fill_q;
    logic       armed_q;
    logic       start_edge;

    // Receive FSM and bit timing
    rx_state_e   state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]  sample_q, sample_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  vote_q, vote_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q;
    logic        tick;
    logic        decide;
    logic        bit_end;
    logic        majority;
    logic        byte_push;

    // FIFO handshake
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    // sync_fill_q marks when rxs_q holds a real line sample rather than the
    // reset value; armed_q then demands a genuine high before any start edge,
    // so a line already low at reset release is never mistaken for a start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta_q  <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_prev_q  <= 1'b1;
            sync_fill_q <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxs_q       <= rxd_meta_q;
            rxs_prev_q  <= rxs_q;
            sync_fill_q <= {sync_fill_q[0], 1'b1};
            armed_q     <= armed_q | (sync_fill_q[1] & rxs_q);
        end
    end

    assign start_edge = armed_q && rxs_prev_q && !rxs_q;

    assign tick     = (tick_cnt_q == TICK_LAST);
    assign decide   = tick && (sample_q == SAMPLE_LAST);
    assign bit_end  = tick && (sample_q == SAMPLE_END);
    // Samples 7 and 8 are latched; sample 9 is the live synchronized value.
    assign majority = majority3(vote_q[0], vote_q[1], rxs_q);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        sample_d    = sample_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        vote_d      = vote_q;
        frame_err_d = 1'b0;
        byte_push   = 1'b0;

        if (state_q != IDLE) begin
            if (tick) begin
                tick_cnt_d = '0;
                sample_d   = sample_q + 4'd1;
                if (sample_q == SAMPLE_FIRST) begin
                    vote_d[0] = rxs_q;
                end
                if (sample_q == SAMPLE_FIRST + 4'd1) begin
                    vote_d[1] = rxs_q;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_ONE;
            end
        end

        unique case (state_q)
            IDLE: begin
                // Counters stay cleared so bit phase is anchored to the edge.
                tick_cnt_d = '0;
                sample_d   = '0;
                if (start_edge) begin
                    state_d   = START;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (decide && majority) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {majority, shift_q[7:1]};
                end
                if (bit_end) begin
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at sample 9 lets the next start edge, which may arrive
                // before the nominal end of the stop bit, be caught in IDLE.
                if (decide) begin
                    if (majority) begin
                        byte_push = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            sample_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            vote_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            sample_q    <= sample_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            vote_q      <= vote_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= byte_push && fifo_full && !fifo_pop;
        end
    end

    assign fifo_pop = rx_valid && rx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (byte_push),
        .push_data_i (shift_q),
        .pop_i       (fifo_pop),
        .pop_data_o  (rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus a randomized
// traffic phase, scored against an expected-byte queue and event counts.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ        = 9_216_003;
    localparam int BAUD_RATE       = 115_200;
    localparam int DEPTH           = 4;
    localparam int CPT             = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT_CLK         = 16 * CPT;
    // Start detection to the stop bit's sample-9 decision: 9 full bits + 10 ticks.
    localparam int DECIDE_CLK      = (9 * 16 + 10) * CPT;
    localparam int FALSE_START_CLK = 10 * CPT;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_fifo #(
        .CLK_FREQUENCY (CLK_FREQ),
        .BAUD          (BAUD_RATE),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: observes the consumer port and flags on the falling edge.
    int         cyc            = 0;
    int         got_n          = 0;
    int         valid_cycles   = 0;
    int         busy_cycles    = 0;
    int         fe_cnt         = 0;
    int         ov_cnt         = 0;
    int         busy_rise_cyc  = 0;
    int         valid_rise_cyc = 0;
    logic       busy_prev      = 1'b0;
    logic       valid_prev     = 1'b0;
    logic [7:0] got_mem [256];

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        busy_prev  <= busy;
        valid_prev <= rx_valid;
        if (reset_n) begin
            if (rx_valid && rx_ready) begin
                got_mem[got_n] <= rx_data;
                got_n          <= got_n + 1;
            end
            if (rx_valid)              valid_cycles   <= valid_cycles + 1;
            if (busy)                  busy_cycles    <= busy_cycles + 1;
            if (frame_err)             fe_cnt         <= fe_cnt + 1;
            if (overrun)               ov_cnt         <= ov_cnt + 1;
            if (busy && !busy_prev)    busy_rise_cyc  <= cyc;
            if (rx_valid && !valid_prev) valid_rise_cyc <= cyc;
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    int         got_base = 0;
    int         fe_base, ov_base, valid_base, busy_base;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic snap();
        fe_base    = fe_cnt;
        ov_base    = ov_cnt;
        valid_base = valid_cycles;
        busy_base  = busy_cycles;
    endtask

    task automatic check_received(input string tag);
        check({tag, "_count"}, got_n - got_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_base + i < got_n) begin
                check($sformatf("%s_byte%0d", tag, i), got_mem[got_base + i], exp_q[i]);
            end
        end
        got_base = got_n;
        exp_q.delete();
    endtask

    // Drives the line for n clocks; callers stay aligned 1 ns after a rising edge.
    task automatic drive_level(input logic v, input int n);
        rxd = v;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int stop_low_bits);
        drive_level(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            drive_level(b[i], BIT_CLK);
        end
        if (stop_ok) drive_level(1'b1, BIT_CLK);
        else         drive_level(1'b0, stop_low_bits * BIT_CLK);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       bad;
        logic       seen;
        logic       rand_done;
        int         exp_fe;

        reset_n  = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        check("reset_busy", busy, 1'b0);
        reset_n = 1'b1;
        drive_level(1'b1, 2 * BIT_CLK);

        // Two clean bytes with a ready consumer.
        rx_ready = 1'b1;
        snap();
        send_byte(8'h55, 1'b1, 0);
        drive_level(1'b1, BIT_CLK);
        check("t1_valid_latency", valid_rise_cyc - busy_rise_cyc, DECIDE_CLK);
        send_byte(8'hA3, 1'b1, 0);
        drive_level(1'b1, BIT_CLK);
        exp_q = '{8'h55, 8'hA3};
        check_received("t1");
        check("t1_valid_cycles", valid_cycles - valid_base, 2);
        check("t1_busy_cycles", busy_cycles - busy_base, 2 * DECIDE_CLK);
        check("t1_frame_err", fe_cnt - fe_base, 0);
        check("t1_overrun", ov_cnt - ov_base, 0);

        // Short low glitch: false start.
        snap();
        drive_level(1'b0, 4 * CPT);
        drive_level(1'b1, 2 * BIT_CLK);
        check("t2_busy_cycles", busy_cycles - busy_base, FALSE_START_CLK);
        check("t2_valid_cycles", valid_cycles - valid_base, 0);
        check("t2_frame_err", fe_cnt - fe_base, 0);
        check("t2_busy_idle", busy, 1'b0);

        // Stop bit low, line held low two bit times.
        snap();
        send_byte(8'hA5, 1'b0, 2);
        check("t3_busy_while_low", busy, 1'b1);
        drive_level(1'b1, BIT_CLK);
        check("t3_frame_err", fe_cnt - fe_base, 1);
        check("t3_valid_cycles", valid_cycles - valid_base, 0);
        check("t3_busy_after_high", busy, 1'b0);

        // Five bytes into a stalled consumer: the fifth overruns.
        rx_ready = 1'b0;
        snap();
        for (int v = 1; v <= 5; v++) begin
            send_byte(8'(v), 1'b1, 0);
        end
        drive_level(1'b1, BIT_CLK);
        check("t4_overrun", ov_cnt - ov_base, 1);
        check("t4_head_valid", rx_valid, 1'b1);
        check("t4_head_data", rx_data, 8'h01);
        rx_ready = 1'b1;
        drive_level(1'b1, 20);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_received("t4");
        check("t4_drained", rx_valid, 1'b0);

        // Full FIFO, consumer accepts exactly on the fifth byte's push cycle.
        rx_ready = 1'b0;
        snap();
        for (int v = 1; v <= 4; v++) begin
            send_byte(8'(v), 1'b1, 0);
        end
        seen = 1'b0;
        fork
            send_byte(8'h05, 1'b1, 0);
            begin
                for (int i = 0; i < 4 * BIT_CLK; i++) begin
                    @(posedge clk);
                    #1;
                    if (busy) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    repeat (DECIDE_CLK - 1) @(posedge clk);
                    #1 rx_ready = 1'b1;
                    @(posedge clk);
                    #1 rx_ready = 1'b0;
                end
            end
        join
        check("t5_busy_seen", seen, 1'b1);
        drive_level(1'b1, BIT_CLK);
        check("t5_overrun", ov_cnt - ov_base, 0);
        exp_q = '{8'h01};
        check_received("t5_pop");
        check("t5_head_data", rx_data, 8'h02);
        rx_ready = 1'b1;
        drive_level(1'b1, 20);
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05};
        check_received("t5");
        check("t5_drained", rx_valid, 1'b0);

        // Reset during data bit 4 with a byte waiting; line low at release.
        rx_ready = 1'b0;
        send_byte(8'h9E, 1'b1, 0);
        drive_level(1'b1, BIT_CLK);
        drive_level(1'b0, 5 * BIT_CLK + BIT_CLK / 2);
        check("t6_busy_before_reset", busy, 1'b1);
        reset_n = 1'b0;
        #2;
        check("t6_rst_rx_valid", rx_valid, 1'b0);
        check("t6_rst_rx_data", rx_data, 8'h00);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_frame_err", frame_err, 1'b0);
        check("t6_rst_overrun", overrun, 1'b0);
        @(posedge clk);
        #1;
        drive_level(1'b0, BIT_CLK);
        check("t6_rst_busy_held", busy, 1'b0);
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        snap();
        drive_level(1'b0, 2 * BIT_CLK);
        drive_level(1'b1, BIT_CLK);
        check("t6_no_start_at_release", busy_cycles - busy_base, 0);
        send_byte(8'h3C, 1'b1, 0);
        drive_level(1'b1, BIT_CLK);
        exp_q = '{8'h3C};
        check_received("t6");
        check("t6_frame_err", fe_cnt - fe_base, 0);

        // Random bytes, random bad stop bits, random gaps and consumer stalls.
        snap();
        exp_fe    = 0;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    b   = 8'($urandom);
                    bad = ($urandom_range(0, 3) == 0);
                    if (bad) begin
                        send_byte(b, 1'b0, 1);
                        drive_level(1'b1, BIT_CLK + $urandom_range(0, BIT_CLK));
                        exp_fe++;
                    end else begin
                        send_byte(b, 1'b1, 0);
                        exp_q.push_back(b);
                        drive_level(1'b1, $urandom_range(0, BIT_CLK));
                    end
                end
                drive_level(1'b1, 2 * BIT_CLK);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rx_ready = 1'b1;
        drive_level(1'b1, 20);
        check("rand_frame_err", fe_cnt - fe_base, exp_fe);
        check("rand_overrun", ov_cnt - ov_base, 0);
        check_received("rand");
        check("rand_drained", rx_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
